// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for pipeline stage buffers: default payload widths,
// occupancy encoding and the saturating event-counter helper.
package cpu_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_INFO_W = 32;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One buffer slot: valid bit plus payload. Clear makes the slot a NOP bubble
// but keeps the sideband so the stage still reports the last PC it held.
module pipe_entry
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int INFO_W = DEF_INFO_W
) (
    input  logic              clk,
    input  logic              cpurst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [INFO_W-1:0] ld_info,
    input  logic              ld_exp,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data,
    output logic [INFO_W-1:0] info,
    output logic              exp
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [INFO_W-1:0] info_q, info_d;
    logic              exp_q, exp_d;

    // Clear wins over load so a kill discards a beat arriving in the same cycle.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        info_d  = info_q;
        exp_d   = exp_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            data_d  = '0;
            exp_d   = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl;
            data_d  = ld_data;
            info_d  = ld_info;
            exp_d   = ld_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            info_q  <= '0;
            exp_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            info_q  <= info_d;
            exp_q   <= exp_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;
    assign info  = info_q;
    assign exp   = exp_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with optional two-entry skid buffer, flush/exception
// kill to a NOP bubble, and a saturating count of kill events.
module pipe_stage_buf
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int INFO_W    = DEF_INFO_W,
    parameter int SKID      = 1,
    parameter int EXP_FLUSH = 1
) (
    input  logic              clk,
    input  logic              cpurst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [INFO_W-1:0] in_info,
    input  logic              in_exp,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [INFO_W-1:0] out_info,
    output logic              out_exp,
    output logic [CNT_W-1:0]  flush_cnt
);

    occ_e             occ_q, occ_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic              accept, retire, kill;
    logic              head_load, head_clear, head_from_skid;
    logic              skid_load, skid_clear;

    logic              head_valid, head_exp;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [INFO_W-1:0] head_info;

    logic              skid_valid, skid_exp;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [INFO_W-1:0] skid_info;

    logic [CTRL_W-1:0] head_ld_ctrl;
    logic [DATA_W-1:0] head_ld_data;
    logic [INFO_W-1:0] head_ld_info;
    logic              head_ld_exp;

    // With the skid slot, in_ready is purely registered; without it, ready follows out_ready.
    assign in_ready = (SKID != 0) ? !skid_valid : (!head_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = head_valid && out_ready;
    assign kill     = flush || ((EXP_FLUSH != 0) && head_valid && head_exp);

    always_comb begin
        occ_d          = occ_q;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (kill) begin
            occ_d      = OCC_EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_load = 1'b1;
                        occ_d     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && retire) begin
                        head_load = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        skid_load = 1'b1;
                        occ_d     = OCC_TWO;
                    end else if (retire) begin
                        head_clear = 1'b1;
                        occ_d      = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (retire) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        occ_d          = OCC_ONE;
                    end
                end
                default: begin
                    occ_d      = OCC_EMPTY;
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        head_ld_ctrl = head_from_skid ? skid_ctrl : in_ctrl;
        head_ld_data = head_from_skid ? skid_data : in_data;
        head_ld_info = head_from_skid ? skid_info : in_info;
        head_ld_exp  = head_from_skid ? skid_exp  : in_exp;
        flush_cnt_d  = kill ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            occ_q       <= OCC_EMPTY;
            flush_cnt_q <= '0;
        end else begin
            occ_q       <= occ_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .INFO_W (INFO_W)
    ) u_head (
        .clk     (clk),
        .cpurst  (cpurst),
        .load    (head_load),
        .clear   (head_clear),
        .ld_ctrl (head_ld_ctrl),
        .ld_data (head_ld_data),
        .ld_info (head_ld_info),
        .ld_exp  (head_ld_exp),
        .valid   (head_valid),
        .ctrl    (head_ctrl),
        .data    (head_data),
        .info    (head_info),
        .exp     (head_exp)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .INFO_W (INFO_W)
            ) u_skid (
                .clk     (clk),
                .cpurst  (cpurst),
                .load    (skid_load),
                .clear   (skid_clear),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .ld_info (in_info),
                .ld_exp  (in_exp),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data),
                .info    (skid_info),
                .exp     (skid_exp)
            );
        end else begin : g_noskid
            logic unused_skid_ctl;
            assign unused_skid_ctl = skid_load | skid_clear;
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
            assign skid_info  = '0;
            assign skid_exp   = 1'b0;
        end
    endgenerate

    assign out_valid = head_valid;
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;
    assign out_info  = head_info;
    assign out_exp   = head_exp;
    assign flush_cnt = flush_cnt_q;

endmodule
